// File: rtl/count_ones_pkg.sv
// Shared types and defaults for the count_ones_sched scheduler and its arbiter.
package count_ones_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH  = 4;
    localparam int DEFAULT_COUNT_WIDTH = 3;

    // Width of an index into n items, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from i_last_grant+1 with wrap-around.
module rr_arbiter
    import count_ones_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_last_grant,
    output logic [NUM_REQ-1:0]  o_grant_onehot,
    output logic [ID_WIDTH-1:0] o_grant_idx,
    output logic                o_grant_valid
);

    always_comb begin
        logic [ID_WIDTH-1:0] cand;
        // NOTE: every output gets a default before the loop so no path leaves a latch.
        o_grant_onehot = '0;
        o_grant_idx    = '0;
        o_grant_valid  = 1'b0;
        cand           = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_WIDTH'((int'(i_last_grant) + off) % NUM_REQ);
            if (!o_grant_valid && i_req[cand]) begin
                o_grant_valid        = 1'b1;
                o_grant_idx          = cand;
                o_grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_ones_sched.sv
// Round-robin scheduler sharing one serial ones-counter among NUM_REQ requesters.
// Optional macro COUNT_ONES_SCHED_EARLY_EXIT_EN finishes a job once no set bits remain.
module count_ones_sched
    import count_ones_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter  int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    localparam int ID_WIDTH    = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          busy,
    output logic [COUNT_WIDTH-1:0]        result,
    output logic                          result_valid,
    output logic [ID_WIDTH-1:0]           result_id
);

    localparam int                    IDX_WIDTH = id_width(DATA_WIDTH);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(DATA_WIDTH - 1);
    localparam logic [ID_WIDTH-1:0]   PTR_RESET = ID_WIDTH'(NUM_REQ - 1);

    generate
        if ((2 ** COUNT_WIDTH) <= DATA_WIDTH || NUM_REQ < 2) begin : g_param_check
            $fatal(1, "count_ones_sched: need NUM_REQ >= 2 and 2**COUNT_WIDTH > DATA_WIDTH");
        end
    endgenerate

    state_t                  r_state;
    logic [NUM_REQ-1:0]      r_gnt;
    logic [DATA_WIDTH-1:0]   r_temp;
    logic [COUNT_WIDTH-1:0]  r_count;
    logic [IDX_WIDTH-1:0]    r_index;
    logic [COUNT_WIDTH-1:0]  r_result;
    logic                    r_result_valid;
    logic [ID_WIDTH-1:0]     r_result_id;
    logic [ID_WIDTH-1:0]     r_last_grant;

    logic [NUM_REQ-1:0]      w_win_onehot;
    logic [ID_WIDTH-1:0]     w_win_idx;
    logic                    w_win_valid;
    logic [DATA_WIDTH-1:0]   w_win_data;
    logic [COUNT_WIDTH-1:0]  w_next_count;
    logic                    w_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req          (req),
        .i_last_grant   (r_last_grant),
        .o_grant_onehot (w_win_onehot),
        .o_grant_idx    (w_win_idx),
        .o_grant_valid  (w_win_valid)
    );

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_onehot[i]) begin
                w_win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_next_count = r_count + COUNT_WIDTH'(r_temp[0]);

`ifdef COUNT_ONES_SCHED_EARLY_EXIT_EN
    // Once only bit 0 can still be set, the final count is already known.
    assign w_done = (r_index == LAST_IDX) || ((r_temp >> 1) == '0);
`else
    assign w_done = (r_index == LAST_IDX);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_gnt          <= '0;
            r_temp         <= '0;
            r_count        <= '0;
            r_index        <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_last_grant   <= PTR_RESET;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_result_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_gnt        <= w_win_onehot;
                        r_temp       <= w_win_data;
                        r_count      <= '0;
                        r_index      <= '0;
                        r_result_id  <= w_win_idx;
                        r_last_grant <= w_win_idx;
                        r_state      <= SHIFT;
                    end else begin
                        r_gnt <= '0;
                    end
                end
                SHIFT: begin
                    r_gnt   <= '0;
                    r_count <= w_next_count;
                    r_temp  <= r_temp >> 1;
                    r_index <= r_index + IDX_WIDTH'(1);
                    if (w_done) begin
                        r_result       <= w_next_count;
                        r_result_valid <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign busy         = (r_state != IDLE);
    assign result       = r_result;
    assign result_valid = r_result_valid;
    assign result_id    = r_result_id;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_gnt_single: assert property (@(posedge clk) disable iff (reset) (gnt != '0) |=> (gnt == '0));
    a_valid_pulse: assert property (@(posedge clk) disable iff (reset) result_valid |=> !result_valid);

endmodule
